// File: rtl/dcache_direct_mapped.sv
// dcache_direct_mapped: direct-mapped data cache, 4 x 32-bit words per line.
//
// Build option: define DCACHE_WRITE_BACK_EN for a write-back, write-allocate
// cache (per-line dirty bits, WRITEBACK state). Without it the cache is
// write-through, write-allocate: every store is sent to memory from the
// WRITETHRU state, and lines are never dirty.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   proc_read/_write    processor load/store request (both high = store)
//   proc_addr[29:0]     word address {tag, index, word offset[1:0]}
//   proc_wdata[31:0]    store data
//   proc_stall          request not complete; processor holds its inputs
//   proc_rdata[31:0]    load data, zero unless proc_read=1 and proc_stall=0
//   mem_read/_write     line fetch / line write request
//   mem_addr[27:0]      line address
//   mem_wdata[127:0]    line write data, word 0 in [31:0]
//   mem_rdata[127:0]    line read data, valid with mem_ready
//   mem_ready           memory completes the current request at this edge
//
// Hits are zero-latency: hit detection, proc_stall, proc_rdata and the
// memory request lines are combinational from the state and request.

module dcache_direct_mapped #(
    parameter int unsigned BLOCK_NUM = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int unsigned IDX    = $clog2(BLOCK_NUM);
    localparam int unsigned TAG_W  = 28 - IDX;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
`ifdef DCACHE_WRITE_BACK_EN
        WRITEBACK = 2'd1,
`else
        WRITETHRU = 2'd3,
`endif
        ALLOCATE  = 2'd2
    } state_t;

    // Line storage
    logic [BLOCK_NUM-1:0] r_valid;
`ifdef DCACHE_WRITE_BACK_EN
    logic [BLOCK_NUM-1:0] r_dirty;
`endif
    logic [TAG_W-1:0]     r_tag  [BLOCK_NUM];
    logic [LINE_W-1:0]    r_data [BLOCK_NUM];

    state_t r_state;
    state_t w_next;

    // Address decode of the (held) processor request
    logic [IDX-1:0]    w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [1:0]        w_off;
    logic [6:0]        w_word_sel;
    logic [LINE_W-1:0] w_line;
    logic [TAG_W-1:0]  w_line_tag;
    logic [WORD_W-1:0] w_rd_word;
    logic [LINE_W-1:0] w_merged;
    logic              w_req;
    logic              w_hit;
    logic              w_fill;
    logic              w_wr_line;

    assign w_idx      = proc_addr[IDX+1:2];
    assign w_tag      = proc_addr[29:IDX+2];
    assign w_off      = proc_addr[1:0];
    assign w_word_sel = {w_off, 5'd0};
    assign w_line     = r_data[w_idx];
    assign w_line_tag = r_tag[w_idx];
    assign w_rd_word  = w_line[w_word_sel +: WORD_W];
    assign w_req      = proc_read | proc_write;
    assign w_hit      = r_valid[w_idx] && (w_line_tag == w_tag);

    // Resident line with the addressed word replaced by the store data
    always_comb begin
        w_merged                        = w_line;
        w_merged[w_word_sel +: WORD_W]  = proc_wdata;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, handshake outputs and storage update strobes
    always_comb begin
        w_next     = r_state;
        proc_stall = 1'b0;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = proc_addr[29:2];
        mem_wdata  = w_line;
        w_fill     = 1'b0;
        w_wr_line  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        // A store wins when read and write are both high
                        if (proc_write) begin
`ifdef DCACHE_WRITE_BACK_EN
                            w_wr_line = 1'b1;
`else
                            proc_stall = 1'b1;
                            w_next     = WRITETHRU;
`endif
                        end
                    end else begin
                        proc_stall = 1'b1;
`ifdef DCACHE_WRITE_BACK_EN
                        w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : ALLOCATE;
`else
                        w_next = ALLOCATE;
`endif
                    end
                end
            end

`ifdef DCACHE_WRITE_BACK_EN
            // Evict the dirty victim to its own line address
            WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {w_line_tag, w_idx};
                mem_wdata  = w_line;
                if (mem_ready) begin
                    w_next = ALLOCATE;
                end
            end
`else
            // Store completes when memory accepts the updated line
            WRITETHRU: begin
                mem_write = 1'b1;
                mem_wdata = w_merged;
                if (mem_ready) begin
                    w_wr_line = 1'b1;
                    w_next    = IDLE;
                end else begin
                    proc_stall = 1'b1;
                end
            end
`endif

            // Fetch the requested line; the access retries as a hit in IDLE
            ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                if (mem_ready) begin
                    w_fill = 1'b1;
                    w_next = IDLE;
                end
            end

            default: begin
                w_next = IDLE;
            end
        endcase

        if (proc_read && !proc_stall) begin
            proc_rdata = w_rd_word;
        end
    end

    // Line storage update; reset wins over a same-edge fill
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
`ifdef DCACHE_WRITE_BACK_EN
            r_dirty <= '0;
`endif
        end else if (w_fill) begin
            r_valid[w_idx] <= 1'b1;
            r_tag[w_idx]   <= w_tag;
            r_data[w_idx]  <= mem_rdata;
`ifdef DCACHE_WRITE_BACK_EN
            r_dirty[w_idx] <= 1'b0;
`endif
        end else if (w_wr_line) begin
            r_data[w_idx]  <= w_merged;
`ifdef DCACHE_WRITE_BACK_EN
            r_dirty[w_idx] <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Self-checking bench for dcache_direct_mapped (BLOCK_NUM = 8).
// Memory is modelled inside the access task: requests complete on their
// MEM_LAT-th active cycle. Expected memory transactions and load data are
// queued before each access and popped as the DUT produces them.

module tb_dcache_direct_mapped;

    localparam int unsigned MEM_LAT = 3;
    localparam int unsigned MAX_CYC = 64;

    typedef struct packed {
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] data;
    } mem_txn_t;

    logic         clk;
    logic         rst_n;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    mem_txn_t     exp_mem_q[$];
    logic [31:0]  exp_rd_q[$];
    logic [127:0] mem_model [16];

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] LINE4_INIT   = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    localparam logic [127:0] LINE4_MERGED = {32'hDDDD0003, 32'hCCCC0002, 32'hDEADBEEF, 32'hAAAA0000};
    localparam logic [127:0] LINE1_MERGED = {32'h10000103, 32'h10000102, 32'h12345678, 32'h10000100};
    localparam logic [127:0] LINE2_MERGED = {32'h10000203, 32'hCAFEF00D, 32'h10000201, 32'h10000200};

    dcache_direct_mapped #(.BLOCK_NUM(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic push_mem(input logic wr, input logic [27:0] a, input logic [127:0] d);
        mem_txn_t t;
        t.wr   = wr;
        t.addr = a;
        t.data = d;
        exp_mem_q.push_back(t);
    endtask

    task automatic idle();
        proc_read  = 1'b0;
        proc_write = 1'b0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        @(negedge clk);
    endtask

    // One processor access from a negedge until it completes; ends on a negedge
    task automatic access(input logic wr, input logic [29:0] addr, input logic [31:0] wdata,
                          input int exp_stalls, input string name);
        int          stalls;
        int unsigned lat;
        bit          done;
        logic [27:0]  held_addr;
        logic [127:0] held_wdata;
        mem_txn_t    e;
        logic [31:0] er;
        stalls     = 0;
        lat        = 0;
        done       = 1'b0;
        held_addr  = '0;
        held_wdata = '0;
        proc_read  = ~wr;
        proc_write = wr;
        proc_addr  = addr;
        proc_wdata = wdata;
        for (int cyc = 0; cyc < int'(MAX_CYC) && !done; cyc++) begin
            mem_ready = 1'b0;
            mem_rdata = '0;
            #1;
            if (mem_read || mem_write) begin
                checks++;
                if ((mem_read && mem_write) || exp_mem_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s mem_req: read=%b write=%b addr=%h, expected one request with %0d queued",
                             name, mem_read, mem_write, mem_addr, exp_mem_q.size());
                end
                if (lat == 0) begin
                    held_addr  = mem_addr;
                    held_wdata = mem_wdata;
                end else begin
                    checks++;
                    if (mem_addr !== held_addr || (mem_write && mem_wdata !== held_wdata)) begin
                        errors++;
                        $display("FAIL %s mem_stable: addr=%h wdata=%h, expected addr=%h wdata=%h",
                                 name, mem_addr, mem_wdata, held_addr, held_wdata);
                    end
                end
                lat++;
                if (lat == MEM_LAT) begin
                    lat       = 0;
                    mem_ready = 1'b1;
                    if (exp_mem_q.size() != 0) begin
                        e = exp_mem_q.pop_front();
                        checks++;
                        if (mem_write !== e.wr || mem_addr !== e.addr || (e.wr && mem_wdata !== e.data)) begin
                            errors++;
                            $display("FAIL %s mem_txn: wr=%b addr=%h data=%h, expected wr=%b addr=%h data=%h",
                                     name, mem_write, mem_addr, mem_wdata, e.wr, e.addr, e.data);
                        end
                    end
                    if (mem_write) mem_model[mem_addr[3:0]] = mem_wdata;
                    else           mem_rdata = mem_model[mem_addr[3:0]];
                end
            end
            #1;
            if (proc_stall !== 1'b1) begin
                done = 1'b1;
                if (!wr) begin
                    checks++;
                    er = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 32'hxxxxxxxx;
                    if (proc_rdata !== er) begin
                        errors++;
                        $display("FAIL %s rdata: got %h, expected %h", name, proc_rdata, er);
                    end
                end
            end else begin
                stalls++;
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        mem_rdata = '0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: still stalled after %0d cycles, expected completion", name, MAX_CYC);
        end
        if (exp_stalls >= 0) begin
            checks++;
            if (stalls != exp_stalls) begin
                errors++;
                $display("FAIL %s stall_cycles: got %0d, expected %0d", name, stalls, exp_stalls);
            end
        end
        checks++;
        if (exp_mem_q.size() != 0 || exp_rd_q.size() != 0) begin
            errors++;
            $display("FAIL %s leftover: %0d mem and %0d read expectations unmet, expected 0",
                     name, exp_mem_q.size(), exp_rd_q.size());
        end
        exp_mem_q.delete();
        exp_rd_q.delete();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (proc_stall !== 1'b0) begin errors++; $display("FAIL reset proc_stall: got %b, expected 0", proc_stall); end
        checks++;
        if (mem_read !== 1'b0) begin errors++; $display("FAIL reset mem_read: got %b, expected 0", mem_read); end
        checks++;
        if (mem_write !== 1'b0) begin errors++; $display("FAIL reset mem_write: got %b, expected 0", mem_write); end
        checks++;
        if (proc_rdata !== 32'h0) begin errors++; $display("FAIL reset proc_rdata: got %h, expected 0", proc_rdata); end
        @(negedge clk);
    endtask

    // Cold read of word 0x10 (line 4), then a hit in the same line
    task automatic test_read_miss();
        push_mem(1'b0, 28'h4, '0);
        exp_rd_q.push_back(32'hAAAA0000);
        access(1'b0, 30'h10, 32'h0, 4, "read_miss");
        exp_rd_q.push_back(32'hDDDD0003);
        access(1'b0, 30'h13, 32'h0, 0, "read_hit");
        idle();
    endtask

    task automatic test_write_hit();
`ifdef DCACHE_WRITE_BACK_EN
        access(1'b1, 30'h11, 32'hDEADBEEF, 0, "write_hit");
`else
        push_mem(1'b1, 28'h4, LINE4_MERGED);
        access(1'b1, 30'h11, 32'hDEADBEEF, 3, "write_hit");
`endif
        exp_rd_q.push_back(32'hDEADBEEF);
        access(1'b0, 30'h11, 32'h0, 0, "write_hit_readback");
        idle();
    endtask

    // Line at index 1 tag 0 is modified, then displaced by tag 1 (line 9)
    task automatic test_evict();
        push_mem(1'b0, 28'h1, '0);
        exp_rd_q.push_back(32'h10000100);
        access(1'b0, 30'h04, 32'h0, 4, "evict_fill");
`ifdef DCACHE_WRITE_BACK_EN
        access(1'b1, 30'h05, 32'h12345678, 0, "evict_dirty_store");
        push_mem(1'b1, 28'h1, LINE1_MERGED);
        push_mem(1'b0, 28'h9, '0);
        exp_rd_q.push_back(32'h10000900);
        access(1'b0, 30'h24, 32'h0, 7, "evict_writeback");
`else
        push_mem(1'b1, 28'h1, LINE1_MERGED);
        access(1'b1, 30'h05, 32'h12345678, 3, "evict_store");
        push_mem(1'b0, 28'h9, '0);
        exp_rd_q.push_back(32'h10000900);
        access(1'b0, 30'h24, 32'h0, 4, "evict_no_writeback");
`endif
        idle();
    endtask

    // Store miss to clean index 2, readback, then displacement by line 10
    task automatic test_write_miss();
        push_mem(1'b0, 28'h2, '0);
`ifdef DCACHE_WRITE_BACK_EN
        access(1'b1, 30'h0A, 32'hCAFEF00D, 4, "write_miss");
`else
        push_mem(1'b1, 28'h2, LINE2_MERGED);
        access(1'b1, 30'h0A, 32'hCAFEF00D, 7, "write_miss");
`endif
        exp_rd_q.push_back(32'hCAFEF00D);
        access(1'b0, 30'h0A, 32'h0, 0, "write_miss_readback");
`ifdef DCACHE_WRITE_BACK_EN
        push_mem(1'b1, 28'h2, LINE2_MERGED);
        push_mem(1'b0, 28'hA, '0);
        exp_rd_q.push_back(32'h10000A00);
        access(1'b0, 30'h28, 32'h0, 7, "write_miss_evict");
`else
        push_mem(1'b0, 28'hA, '0);
        exp_rd_q.push_back(32'h10000A00);
        access(1'b0, 30'h28, 32'h0, 4, "write_miss_evict");
`endif
        idle();
    endtask

    // Consecutive hits across several resident lines
    task automatic test_back_to_back();
        exp_rd_q.push_back(32'hAAAA0000);
        access(1'b0, 30'h10, 32'h0, 0, "b2b_0");
        exp_rd_q.push_back(32'hDEADBEEF);
        access(1'b0, 30'h11, 32'h0, 0, "b2b_1");
        exp_rd_q.push_back(32'h10000901);
        access(1'b0, 30'h25, 32'h0, 0, "b2b_2");
        exp_rd_q.push_back(32'h10000A01);
        access(1'b0, 30'h29, 32'h0, 0, "b2b_3");
        exp_rd_q.push_back(32'hCCCC0002);
        access(1'b0, 30'h12, 32'h0, 0, "b2b_4");
        idle();
    endtask

    // Reset lands on the same edge as mem_ready during ALLOCATE of line 6
    task automatic test_reset_mid_alloc();
        proc_read  = 1'b1;
        proc_write = 1'b0;
        proc_addr  = 30'h18;
        #1;
        checks++;
        if (proc_stall !== 1'b1) begin errors++; $display("FAIL rst_alloc miss_stall: got %b, expected 1", proc_stall); end
        @(negedge clk);
        #1;
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h6) begin
            errors++;
            $display("FAIL rst_alloc fetch: mem_read=%b addr=%h, expected 1 and 6", mem_read, mem_addr);
        end
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = mem_model[6];
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        proc_read = 1'b0;
        #1;
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || proc_stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_alloc after_reset: mem_read=%b mem_write=%b stall=%b, expected 0 0 0",
                     mem_read, mem_write, proc_stall);
        end
        @(negedge clk);
        push_mem(1'b0, 28'h6, '0);
        exp_rd_q.push_back(32'h10000600);
        access(1'b0, 30'h18, 32'h0, 4, "rst_alloc_reread");
        idle();
    endtask

    initial begin
        for (int l = 0; l < 16; l++) begin
            for (int w = 0; w < 4; w++) begin
                mem_model[l][w*32 +: 32] = 32'h10000000 + 32'(l * 256 + w);
            end
        end
        mem_model[4] = LINE4_INIT;
        proc_wdata   = '0;
        proc_addr    = '0;

        test_reset();
        test_read_miss();
        test_write_hit();
        test_evict();
        test_write_miss();
        test_back_to_back();
        test_reset_mid_alloc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_direct_mapped.md
DCACHE_DIRECT_MAPPED -- requirements
Module: dcache_direct_mapped

Interface
REQ-001 SHALL have parameter BLOCK_NUM, default 8, number of cache lines (power of two, 2..64); IDX = log2(BLOCK_NUM).
REQ-002 SHALL have port clk input 1, clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n input 1, reset, synchronous, active-low.
REQ-004 SHALL have port proc_read input 1, processor load request.
REQ-005 SHALL have port proc_write input 1, processor store request.
REQ-006 SHALL have port proc_addr input 30, word address: [1:0] word offset, [IDX+1:2] index, [29:IDX+2] tag.
REQ-007 SHALL have port proc_wdata input 32, store data.
REQ-008 SHALL have port proc_stall output 1, request not complete; processor holds all request inputs while high.
REQ-009 SHALL have port proc_rdata output 32, load data, valid when proc_read=1 and proc_stall=0.
REQ-010 SHALL have port mem_read output 1, line fetch request.
REQ-011 SHALL have port mem_write output 1, line write request.
REQ-012 SHALL have port mem_addr output 28, line address (word address >> 2).
REQ-013 SHALL have port mem_wdata output 128, line write data, word 0 in bits [31:0].
REQ-014 SHALL have port mem_rdata input 128, line read data, valid when mem_ready=1.
REQ-015 SHALL have port mem_ready input 1, memory completes current request at this edge.

Function
REQ-016 SHALL be direct-mapped, 4 words per line, with per-line valid, dirty, and tag storage.
REQ-017 SHALL use FSM states IDLE, WRITEBACK, ALLOCATE.
REQ-018 SHALL, in IDLE with a request, compute hit = valid[idx] and tag match, combinationally, in the same cycle.
REQ-019 SHALL, on a read hit, drive proc_stall=0 and proc_rdata = the addressed word in the same cycle (zero-latency hit).
REQ-020 SHALL, on a write hit, drive proc_stall=0, write proc_wdata into the addressed word at the edge, and set dirty.
REQ-021 SHALL, on a miss, drive proc_stall=1 combinationally; go to WRITEBACK if valid and dirty, else to ALLOCATE.
REQ-022 SHALL, in WRITEBACK, hold mem_write=1, mem_addr={old tag, idx}, and mem_wdata=line; on mem_ready go to ALLOCATE.
REQ-023 SHALL, in ALLOCATE, hold mem_read=1 and mem_addr=proc_addr[29:2]; on mem_ready load mem_rdata, set valid, set tag, clear dirty, and go to IDLE.
REQ-024 SHALL keep proc_stall=1 in WRITEBACK and ALLOCATE; the retried access hits in IDLE the following cycle (write-allocate for stores).
REQ-025 SHALL treat proc_read=1 and proc_write=1 together as a write.
REQ-026 SHALL, with no request in IDLE, drive proc_stall=0, mem_read=0, mem_write=0, and leave state unchanged.
REQ-027 SHALL never assert mem_read and mem_write in the same cycle.
REQ-028 SHALL hold mem_addr and mem_wdata stable while a request is pending and mem_ready=0.

Reset
REQ-029 SHALL, while rst_n=0 at an edge, clear all valid and dirty bits and set the state to IDLE; mem_read=0, mem_write=0, proc_stall=0 for the following cycle.
REQ-030 SHALL, on reset mid-WRITEBACK or mid-ALLOCATE, abandon the memory transaction, and ignore mem_ready in that cycle.
REQ-031 SHALL drive proc_rdata to 0 whenever proc_read=0 or proc_stall=1.

Configuration
REQ-032 SHALL, with macro DCACHE_WRITE_BACK_EN defined, implement the write-back behaviour of REQ-020..REQ-023.
REQ-033 SHALL, without DCACHE_WRITE_BACK_EN, be write-through: no dirty bits, no WRITEBACK state.
REQ-034 SHALL, without DCACHE_WRITE_BACK_EN, handle every store in added state WRITETHRU.
- Entry: a store in IDLE that hits goes directly to WRITETHRU; a store that misses first completes ALLOCATE, then retries in IDLE and goes to WRITETHRU.
- In WRITETHRU: hold mem_write=1 with the updated line and proc_stall=1; return to IDLE on mem_ready.

Verification
REQ-035 SHALL test: reset, then read 0x0000_0010 with mem_ready after 3 cycles, mem_rdata={D,C,B,A} -> one mem_read of line 0x4, stall 4 cycles, then proc_rdata=A with no stall.
REQ-036 SHALL test: write 0xDEADBEEF to a resident word -> proc_stall=0 that cycle and no mem access; a read of the same address returns 0xDEADBEEF.
REQ-037 SHALL test: with a dirty line at index 1 (tag 0), read a tag-1 address at the same index -> mem_write of old line first, then mem_read, then data.
REQ-038 SHALL test: write miss to a clean index -> ALLOCATE only, merged word visible; a later eviction writes back the merged line.
REQ-039 SHALL test: rst_n low during ALLOCATE with mem_ready=1 -> line stays invalid, mem_read=0, and a re-read misses.
REQ-040 SHALL test: without DCACHE_WRITE_BACK_EN, a write hit -> mem_write=1 with the updated line and stall until mem_ready; eviction causes no writeback.
